// File: rtl/inst_fetch.sv
// Fetch stage in front of a fixed-latency instruction memory: generates the PC stream,
// tracks in-flight reads and buffers returned instructions for decode.
module inst_fetch #(
    parameter int                ADDR_W     = 64,
    parameter int                INST_W     = 32,
    parameter int                MEM_LAT    = 3,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [INST_W-1:0] i_imem_inst,
    input  logic              i_redir_vld,
    input  logic [ADDR_W-1:0] i_redir_pc,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W:0]   DEPTH_V  = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [ADDR_W-1:0]  r_pc;
    logic [MEM_LAT-1:0] r_trk_vld;
    logic [ADDR_W-1:0]  r_trk_pc    [MEM_LAT];
    logic [INST_W-1:0]  r_fifo_inst [FIFO_DEPTH];
    logic [ADDR_W-1:0]  r_fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [CNT_W:0] w_credit_used;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic           w_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit = buffered entries plus reads still travelling through the memory.
    // NOTE: the accumulator gets its default before the loop so no latch is inferred.
    always_comb begin
        w_credit_used = {1'b0, r_count};
        for (int k = 0; k < MEM_LAT; k++) begin
            w_credit_used = w_credit_used + {{CNT_W{1'b0}}, r_trk_vld[k]};
        end
    end

    assign w_issue     = !i_redir_vld && (w_credit_used < DEPTH_V);
    assign w_push      = r_trk_vld[MEM_LAT-1] && !i_redir_vld;
    assign w_empty     = (r_count == '0);
    assign o_valid     = !w_empty && !i_redir_vld;
    assign w_pop       = o_valid && i_ready;
    assign o_inst      = w_empty ? '0 : r_fifo_inst[r_rd_ptr];
    assign o_pc        = w_empty ? '0 : r_fifo_pc[r_rd_ptr];
    assign o_imem_addr = r_pc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_trk_vld <= '0;
        end else if (i_redir_vld) begin
            r_pc      <= {i_redir_pc[ADDR_W-1:2], 2'b00};
            r_trk_vld <= '0;
        end else begin
            r_trk_vld <= (r_trk_vld << 1) | MEM_LAT'(w_issue);
            if (w_issue) begin
                r_pc <= r_pc + ADDR_W'(4);
            end
        end
    end

    // NOTE: tracker PCs and FIFO storage carry no reset; they are only read when qualified by valid/count.
    always_ff @(posedge i_clk) begin
        r_trk_pc[0] <= r_pc;
        for (int k = 1; k < MEM_LAT; k++) begin
            r_trk_pc[k] <= r_trk_pc[k-1];
        end
        if (w_push) begin
            r_fifo_inst[r_wr_ptr] <= i_imem_inst;
            r_fifo_pc[r_wr_ptr]   <= r_trk_pc[MEM_LAT-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_redir_vld) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // The credit check must make a full-FIFO push impossible.
    a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(w_push && (r_count == FULL_CNT)));

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed latency/backpressure/redirect/reset
// scenarios followed by randomized ready/redirect traffic against an in-order PC model.
module tb_inst_fetch;

    localparam int          ADDR_W     = 64;
    localparam int          INST_W     = 32;
    localparam int          MEM_LAT    = 3;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [63:0] RESET_PC   = 64'h0;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [INST_W-1:0] i_imem_inst;
    logic              i_redir_vld;
    logic [ADDR_W-1:0] i_redir_pc;
    logic              o_valid;
    logic              i_ready;
    logic [INST_W-1:0] o_inst;
    logic [ADDR_W-1:0] o_pc;

    inst_fetch #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .MEM_LAT(MEM_LAT),
        .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_imem_addr(o_imem_addr),
        .i_imem_inst(i_imem_inst), .i_redir_vld(i_redir_vld), .i_redir_pc(i_redir_pc),
        .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc)
    );

    always #5 i_clk = ~i_clk;

    // Memory contents: word at byte address a holds 0x1000 + a/4.
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return 32'h1000 + a[33:2];
    endfunction

    // Instruction memory with fixed read latency.
    logic [63:0] mem_a [MEM_LAT];
    always @(posedge i_clk) begin
        mem_a[0] <= o_imem_addr;
        for (int k = 1; k < MEM_LAT; k++) mem_a[k] <= mem_a[k-1];
    end
    assign i_imem_inst = mem_f(mem_a[MEM_LAT-1]);

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_xfer   = 0;
    int          since_redir = 0;
    logic [63:0] exp_pc, prev_addr, prev_tgt;
    logic        prev_redir;
    logic        s_valid;
    logic [63:0] s_pc, s_addr;
    logic [31:0] s_inst;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle: sample outputs mid-cycle, apply the reference model, advance to next negedge.
    task automatic tick();
        #1;
        s_valid = o_valid;
        s_pc    = o_pc;
        s_inst  = o_inst;
        s_addr  = o_imem_addr;
        since_redir++;
        if (prev_redir) check("addr_after_redir", s_addr, prev_tgt);
        else check("addr_step", 64'((s_addr == prev_addr) || (s_addr == prev_addr + 64'd4)), 64'd1);
        if (s_valid) check("valid_not_early", 64'(since_redir >= MEM_LAT + 2), 64'd1);
        if (i_redir_vld) begin
            check("valid_low_on_redir", 64'(s_valid), 64'd0);
        end else if (s_valid && i_ready) begin
            check("xfer_pc", s_pc, exp_pc);
            check("xfer_inst", 64'(s_inst), 64'(mem_f(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_xfer++;
        end
        prev_addr  = s_addr;
        prev_redir = i_redir_vld;
        prev_tgt   = {i_redir_pc[63:2], 2'b00};
        if (i_redir_vld) begin
            exp_pc      = prev_tgt;
            since_redir = 0;
        end
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_redir_vld = 1'b0;
        #1;
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_addr", o_imem_addr, RESET_PC);
        check("rst_pc", o_pc, 64'd0);
        check("rst_inst", 64'(o_inst), 64'd0);
        exp_pc      = RESET_PC;
        prev_addr   = RESET_PC;
        prev_redir  = 1'b0;
        since_redir = 0;
        n_xfer      = 0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic stream_from_reset(input string tag);
        i_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            tick();
            check({tag, "_valid_timing"}, 64'(s_valid), 64'(c >= MEM_LAT + 1));
        end
        check({tag, "_xfer_count"}, 64'(n_xfer), 64'd12);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        int n;
        n = 0;
        while (!o_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(o_valid), 64'd1);
    endtask

    initial begin
        int xfer_base;
        i_rst_n     = 1'b1;
        i_ready     = 1'b1;
        i_redir_vld = 1'b0;
        i_redir_pc  = '0;
        @(negedge i_clk);

        // Reset release and steady streaming.
        do_reset();
        stream_from_reset("s1");

        // Fill the FIFO, then reset mid-stream and restart.
        i_ready = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        check("s6_full_valid", 64'(s_valid), 64'd1);
        do_reset();
        stream_from_reset("s6");

        // Backpressure from reset: address must stall once the credit is exhausted.
        do_reset();
        i_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c >= FIFO_DEPTH) check("s2_addr_stall", s_addr, RESET_PC + 64'd32);
            check("s2_valid", 64'(s_valid), 64'(c >= MEM_LAT + 1));
        end
        i_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("s2_no_gap", 64'(s_valid), 64'd1);
        end
        check("s2_xfer_count", 64'(n_xfer), 64'd20);

        // Redirect with three reads in flight and two entries buffered.
        do_reset();
        i_ready = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        i_ready     = 1'b1;
        i_redir_vld = 1'b1;
        i_redir_pc  = 64'h43;
        tick();
        i_redir_vld = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("s3_valid_low", 64'(s_valid), 64'd0);
        end
        tick();
        check("s3_valid", 64'(s_valid), 64'd1);
        check("s3_pc", s_pc, 64'h40);
        check("s3_inst", 64'(s_inst), 64'h1010);
        for (int c = 0; c < 6; c++) tick();

        // Redirect in a cycle where a transfer would otherwise happen.
        check("s4_pre_valid", 64'(o_valid), 64'd1);
        i_redir_vld = 1'b1;
        i_redir_pc  = 64'h300;
        tick();
        check("s4_no_xfer", 64'(s_valid), 64'd0);
        i_redir_vld = 1'b0;
        wait_valid(10, "s4_valid");
        tick();
        check("s4_first_pc", s_pc, 64'h300);

        // Back-to-back redirects: the later target wins.
        i_redir_vld = 1'b1;
        i_redir_pc  = 64'h100;
        tick();
        i_redir_pc  = 64'h200;
        tick();
        i_redir_vld = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            tick();
            check("s5_valid_timing", 64'(s_valid), 64'(c >= 6));
            if (c == 6) check("s5_first_pc", s_pc, 64'h200);
        end

        // Randomized ready and redirects, including targets near the top of the address space.
        xfer_base = n_xfer;
        for (int c = 0; c < 3000; c++) begin
            i_ready     = ($urandom_range(0, 9) < 7);
            i_redir_vld = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 3) == 0) i_redir_pc = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            else i_redir_pc = {32'($urandom), 32'($urandom)};
            tick();
        end
        i_redir_vld = 1'b0;
        i_ready     = 1'b1;
        for (int c = 0; c < 20; c++) tick();
        check("rand_progress", 64'((n_xfer - xfer_base) > 500), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
